// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, default
// reset vector and MIPS-style instruction field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction field bit positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int TGT_MSB   = 25;  // jump target field is [25:0]
    localparam int IMM_MSB   = 15;  // branch immediate field is [15:0]

endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc: combinational next-PC selection for the fetch unit.
// Jump beats branch beats sequential; all arithmetic wraps modulo 2^32.
module next_pc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    output logic [31:0] npc
);

    logic [31:0] imm_ext;
    logic [31:0] btarget;
    logic [31:0] jtarget;

    // Sign-extended word offset, already scaled by 4
    assign imm_ext = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
    assign btarget = pc_plus4 + imm_ext;
    assign jtarget = {pc_plus4[31:28], instr[TGT_MSB:0], 2'b00};

    // Priority select of the next fetch address
    always_comb begin
        npc = pc_plus4;
        if (jump)
            npc = jtarget;
        else if (branch)
            npc = btarget;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: BOOT -> FETCH -> HOLD instruction fetch sequencer.
// Requests one word at pc, holds it for decode/execute until exec_done,
// then advances pc via next_pc.
// Optional feature: define FETCH_RETIRE_CNT_EN to add the retire_cnt output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        exec_done,
    input  logic        pcSource,
    input  logic        jump,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  Op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    state_t      state, state_nxt;
    logic [31:0] npc;
    logic        retire;

    // Control inputs only matter while an instruction is held
    assign retire  = (state == HOLD) && exec_done;

    assign Op      = instr[OP_MSB:OP_LSB];
    assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
    assign pcPlus4 = pc + 32'd4;

    next_pc u_next_pc (
        .pc_plus4 (pcPlus4),
        .instr    (instr),
        .jump     (jump),
        .branch   (pcSource),
        .npc      (npc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    // Next-state and Moore outputs; ack outside FETCH is ignored
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        imem_addr   = pc;
        unique case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = HOLD;
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (exec_done)
                    state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // PC and instruction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            instr <= 32'h0;
        end else begin
            if (state == FETCH && imem_ack)
                instr <= imem_rdata;
            if (retire)
                pc <= npc;
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    // Count retired instructions, free-running wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retire_cnt <= 32'h0;
        else if (retire)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a chained table of fetch/execute
// vectors followed by reset-abort sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        pcSource;
    logic        jump;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  Op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .exec_done   (exec_done),
        .pcSource    (pcSource),
        .jump        (jump),
        .instr       (instr),
        .instr_valid (instr_valid),
        .Op          (Op),
        .funct       (funct),
        .pc          (pc),
        .pcPlus4     (pcPlus4)
`ifdef FETCH_RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        jmp;
        logic        br;
        logic [31:0] pc_exp;
        logic [31:0] npc_exp;
        logic [5:0]  op_exp;
        logic [5:0]  fn_exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Chained: each npc_exp is the next vector's pc_exp
        vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 6'h08, 6'h05};
        vecs[1]  = '{32'h1000_0003, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0014, 6'h04, 6'h03};
        vecs[2]  = '{32'h0800_0040, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0100, 6'h02, 6'h00};
        vecs[3]  = '{32'h1000_FFFF, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 6'h04, 6'h3F};
        vecs[4]  = '{32'h0800_0080, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 6'h02, 6'h00};
        vecs[5]  = '{32'h0800_0040, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0100, 6'h02, 6'h00};
        vecs[6]  = '{32'h0FFF_FFFF, 1'b1, 1'b0, 32'h0000_0100, 32'h0FFF_FFFC, 6'h03, 6'h3F};
        vecs[7]  = '{32'h1000_8000, 1'b0, 1'b1, 32'h0FFF_FFFC, 32'h0FFE_0000, 6'h04, 6'h00};
        vecs[8]  = '{32'h0800_0000, 1'b1, 1'b0, 32'h0FFE_0000, 32'h0000_0000, 6'h02, 6'h00};
        vecs[9]  = '{32'h1000_FFFE, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 6'h04, 6'h3E};
        vecs[10] = '{32'h0000_0020, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 6'h00, 6'h20};
        vecs[11] = '{32'h1000_0001, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 6'h04, 6'h01};

        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        pcSource   = 1'b0;
        jump       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
`ifdef FETCH_RETIRE_CNT_EN
        chk("rst_retire_cnt", retire_cnt, 32'h0);
`endif

        // Release into BOOT; a stray ack here must be discarded
        reset    = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("boot_imem_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("boot_exit_fetch_req", {31'h0, imem_req}, 32'h1);
        chk("boot_ack_discarded", instr, 32'h0);

        for (int i = 0; i < 12; i++) begin
            int unsigned dly;
            dly = (i == 0) ? 3 : (i % 4);
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, 32'h1);
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc_exp);
            // Wait for ack; odd vectors inject control noise that must be ignored
            for (int w = 0; w < int'(dly); w++) begin
                exec_done = i[0];
                jump      = i[0];
                pcSource  = i[0];
                @(negedge clk);
                chk($sformatf("v%0d_w%0d_req", i, w), {31'h0, imem_req}, 32'h1);
                chk($sformatf("v%0d_w%0d_addr", i, w), imem_addr, vecs[i].pc_exp);
            end
            exec_done  = 1'b0;
            jump       = 1'b0;
            pcSource   = 1'b0;
            imem_ack   = 1'b1;
            imem_rdata = vecs[i].rdata;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("v%0d_hold_req", i), {31'h0, imem_req}, 32'h0);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
            chk($sformatf("v%0d_op", i), {26'h0, Op}, {26'h0, vecs[i].op_exp});
            chk($sformatf("v%0d_funct", i), {26'h0, funct}, {26'h0, vecs[i].fn_exp});
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc_exp);
            chk($sformatf("v%0d_pcplus4", i), pcPlus4, vecs[i].pc_exp + 32'd4);
            // Some vectors linger in HOLD with an ack that must be ignored
            if (i % 3 == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                @(negedge clk);
                imem_ack   = 1'b0;
                chk($sformatf("v%0d_linger_valid", i), {31'h0, instr_valid}, 32'h1);
                chk($sformatf("v%0d_linger_instr", i), instr, vecs[i].rdata);
            end
            exec_done = 1'b1;
            jump      = vecs[i].jmp;
            pcSource  = vecs[i].br;
            @(negedge clk);
            exec_done = 1'b0;
            jump      = 1'b0;
            pcSource  = 1'b0;
            chk($sformatf("v%0d_next_addr", i), imem_addr, vecs[i].npc_exp);
            chk($sformatf("v%0d_valid_drop", i), {31'h0, instr_valid}, 32'h0);
        end

`ifdef FETCH_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, 32'd12);
`endif

        // Reset pulsed mid-FETCH at pc=4; ack right after release is discarded
        chk("pre_rst_addr", imem_addr, 32'h0000_0004);
        reset = 1'b1;
        #1;
        chk("async_rst_req", {31'h0, imem_req}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("rst_fetch_req", {31'h0, imem_req}, 32'h1);
        chk("rst_fetch_addr", imem_addr, 32'h0);
        chk("rst_fetch_instr", instr, 32'h0);
        chk("rst_fetch_valid", {31'h0, instr_valid}, 32'h0);
`ifdef FETCH_RETIRE_CNT_EN
        chk("rst_retire_cnt2", retire_cnt, 32'h0);
`endif

        // Reset mid-HOLD aborts the held instruction
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack   = 1'b0;
        chk("hold2_valid", {31'h0, instr_valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk("hold_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("hold_rst_instr", instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word-aligned address loaded into the PC on reset.
REQ-002 Ports (clock and reset first):
  clk  in  1  single clock, all state rising-edge.
  reset  in  1  asynchronous, active-high.
  imem_req  out  1  instruction-memory read request.
  imem_addr  out  32  read address (equals pc).
  imem_ack  in  1  read data valid this cycle.
  imem_rdata  in  32  instruction word.
  exec_done  in  1  datapath has finished the held instruction.
  pcSource  in  1  branch taken, from control unit.
  jump  in  1  jump, from control unit.
  instr  out  32  held instruction word.
  instr_valid  out  1  instr is valid for decode and execute.
  Op  out  6  instr[31:26].
  funct  out  6  instr[5:0].
  pc  out  32  address of the held instruction.
  pcPlus4  out  32  pc + 4.
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 FSM states: BOOT, FETCH, HOLD.
REQ-005 BOOT: the FSM goes to FETCH unconditionally on the next edge.
REQ-006 FETCH: imem_req=1 and imem_addr=pc, both held stable until ack.
REQ-007 FETCH with imem_ack=1: capture instr <= imem_rdata and go to HOLD; fetch latency is 1 cycle after ack.
REQ-008 HOLD: instr_valid=1 and imem_req=0; imem_ack is ignored.
REQ-009 HOLD with exec_done=1: update pc per REQ-010..012, go to FETCH; instr_valid=0 from the next cycle.
REQ-010 Next-PC priority: jump over pcSource over pcPlus4.
REQ-011 Jump target = {pcPlus4[31:28], instr[25:0], 2'b00}.
REQ-012 Branch target = pcPlus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-013 pcPlus4 wraps modulo 2^32: 32'hFFFF_FFFC yields 0.
REQ-014 exec_done, pcSource and jump are ignored outside HOLD.
REQ-015 imem_ack is ignored outside FETCH.
REQ-016 Op, funct and pcPlus4 are combinational from instr and pc.
REQ-017 Back-to-back: exec_done in the same cycle as instr_valid first rises is legal; the PC updates on that edge.

Reset
REQ-018 Reset values: state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
REQ-019 Reset asserted mid-fetch or mid-hold aborts the operation; an ack arriving after reset release while in BOOT is discarded.

Configuration
REQ-020 Macro FETCH_RETIRE_CNT_EN:
  defined: adds output retire_cnt (32), reset 0, +1 on each HOLD cycle with exec_done=1, wraps at 2^32.
  undefined: the port and the counter do not exist; all other behaviour is identical.

Structure
REQ-021 Package fetch_pkg holds the state enum (BOOT/FETCH/HOLD), the default RESET_PC, and the instruction field bit-position constants.
REQ-022 One sub-module, next_pc: combinational target computation and priority mux per REQ-010..012; the FSM and registers stay in fetch_unit.

Verification
REQ-023 Reset release, imem_ack 3 cycles later with rdata=32'h2008_0005 -> imem_addr=0 throughout, instr_valid=1, Op=6'h08, pc=0.
REQ-024 HOLD with instr=32'h1000_FFFF, pc=32'h100, pcSource=1, exec_done=1 -> next imem_addr=32'h100.
REQ-025 HOLD with instr=32'h0800_0040, pc=32'h200, jump=1 and pcSource=1, exec_done=1 -> next imem_addr=32'h100 (jump wins).
REQ-026 pc=32'hFFFF_FFFC, no branch/jump, exec_done=1 -> next pc=0.
REQ-027 Reset pulsed while in FETCH, with ack arriving 1 cycle after release -> ack discarded, instr=0, fetch restarts at RESET_PC.
REQ-028 With FETCH_RETIRE_CNT_EN, 5 exec_done pulses plus 2 exec_done pulses while in FETCH -> retire_cnt=5.
